// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned BYTE_IDX_W = 2;

   localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/word_assembler.sv
// Shifts incoming bytes MSB-first into a 32-bit word; flags the byte that completes it.
module word_assembler
   import program_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              byte_strobe,
   input  logic [BYTE_W-1:0] rx_byte,
   output logic [WORD_W-1:0] word,
   output logic              word_valid,
   output logic              word_full_c
);

   logic [BYTE_IDX_W-1:0] idx;

   // Current strobe carries the last byte of a word.
   assign word_full_c = byte_strobe && !clr && (idx == BYTE_IDX_W'(3));

   always_ff @(posedge clk) begin
      if (!rst) begin
         word       <= '0;
         idx        <= '0;
         word_valid <= 1'b0;
      end else if (clr) begin
         word       <= '0;
         idx        <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= word_full_c;
         if (byte_strobe) begin
            word <= {word[WORD_W-BYTE_W-1:0], rx_byte};
            idx  <= idx + BYTE_IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/program_loader.sv
// Assembles UART bytes into instruction words and writes them sequentially into instruction memory.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned       MEM_DEPTH      = 256,
   parameter int unsigned       TIMEOUT_CYCLES = 1_000_000,
   parameter logic [WORD_W-1:0] HALT_WORD      = HALT_WORD_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_done,
   output logic              loadProgram,
   output logic [WORD_W-1:0] addressInstrucctionProgram,
   output logic [WORD_W-1:0] data_instruction,
   output logic              wr_instruction,
   output logic              load_done,
   output logic              load_error,
   output logic [WORD_W-1:0] word_count
);

   localparam int unsigned       TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WORD_W-1:0] LAST_ADDR = WORD_W'(MEM_DEPTH - 1);

   state_t              state, next_state;
   logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_d;
   logic [WORD_W-1:0]   addr, addr_d, count, count_d;
   logic [WORD_W-1:0]   word;
   logic                load_program_d, load_done_d, load_error_d;
   logic                start_c, timeout_c, write_continue_c;
   logic                asm_clr_c, asm_strobe_c, word_full_c, word_valid;

   assign start_c          = load_start && (state == ST_IDLE || state == ST_ERROR);
   assign timeout_c        = (state == ST_RECV) && !rx_done && (tmo_cnt == TMO_LAST);
   assign write_continue_c = (word != HALT_WORD) && (addr != LAST_ADDR);
   // A byte landing in WRITE starts the next word only if the session continues.
   assign asm_strobe_c     = rx_done && ((state == ST_RECV) ||
                                         (state == ST_WRITE && write_continue_c));
   assign asm_clr_c        = start_c || timeout_c;

   word_assembler u_word_assembler (
      .clk         (clk),
      .rst         (rst),
      .clr         (asm_clr_c),
      .byte_strobe (asm_strobe_c),
      .rx_byte     (rx_data),
      .word        (word),
      .word_valid  (word_valid),
      .word_full_c (word_full_c)
   );

   always_ff @(posedge clk) begin : state_reg
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin : next_state_logic
      next_state = state;
      case (state)
         ST_IDLE:  if (load_start) next_state = ST_RECV;
         ST_RECV: begin
            if (timeout_c)        next_state = ST_ERROR;
            else if (word_full_c) next_state = ST_WRITE;
         end
         ST_WRITE: begin
            if (word == HALT_WORD)      next_state = ST_DONE;
            else if (addr == LAST_ADDR) next_state = ST_ERROR;
            else                        next_state = ST_RECV;
         end
         ST_DONE:  next_state = ST_IDLE;
         ST_ERROR: if (load_start) next_state = ST_RECV;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_comb begin : output_logic
      addr_d    = addr;
      count_d   = count;
      tmo_cnt_d = tmo_cnt;
      if (start_c) begin
         addr_d    = '0;
         count_d   = '0;
         tmo_cnt_d = '0;
      end else begin
         case (state)
            ST_RECV: begin
               if (rx_done || timeout_c) tmo_cnt_d = '0;
               else                      tmo_cnt_d = tmo_cnt + TMO_W'(1);
            end
            ST_WRITE: begin
               count_d = count + WORD_W'(1);
               if (write_continue_c) addr_d = addr + WORD_W'(1);
            end
            default: ;
         endcase
      end
      load_program_d = (next_state == ST_RECV) || (next_state == ST_WRITE);
      load_done_d    = (next_state == ST_DONE);
      load_error_d   = (next_state == ST_ERROR);
   end

   always_ff @(posedge clk) begin : output_reg
      if (!rst) begin
         addr        <= '0;
         count       <= '0;
         tmo_cnt     <= '0;
         loadProgram <= 1'b0;
         load_done   <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         addr        <= addr_d;
         count       <= count_d;
         tmo_cnt     <= tmo_cnt_d;
         loadProgram <= load_program_d;
         load_done   <= load_done_d;
         load_error  <= load_error_d;
      end
   end

   assign addressInstrucctionProgram = addr;
   assign word_count                 = count;
   assign data_instruction           = word;
   assign wr_instruction             = word_valid;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued at stimulus, checked at each strobe.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        loadProgram;
   logic [31:0] addressInstrucctionProgram;
   logic [31:0] data_instruction;
   logic        wr_instruction;
   logic        load_done;
   logic        load_error;
   logic [31:0] word_count;

   int          vectors     = 0;
   int          miscompares = 0;
   int          done_cnt    = 0;
   logic [31:0] exp_done_count = '0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_e;

   always #5 clk = ~clk;

   program_loader #(
      .MEM_DEPTH      (4),
      .TIMEOUT_CYCLES (16),
      .HALT_WORD      (32'hFFFF_FFFF)
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .load_start                 (load_start),
      .rx_data                    (rx_data),
      .rx_done                    (rx_done),
      .loadProgram                (loadProgram),
      .addressInstrucctionProgram (addressInstrucctionProgram),
      .data_instruction           (data_instruction),
      .wr_instruction             (wr_instruction),
      .load_done                  (load_done),
      .load_error                 (load_error),
      .word_count                 (word_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Write strobes and done pulses are checked wherever they occur.
   always @(negedge clk) begin
      if (wr_instruction) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'(wr_instruction), 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check("wr_addr", addressInstrucctionProgram, exp_e[63:32]);
            check("wr_data", data_instruction, exp_e[31:0]);
         end
      end
      if (load_done) begin
         done_cnt++;
         check("done_word_count", word_count, exp_done_count);
         check("done_loadprog", 32'(loadProgram), 32'd0);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input logic [31:0] a, input int gap);
      logic [31:0] v;
      v = w;
      exp_q.push_back({a, w});
      for (int i = 0; i < 4; i++) begin
         send_byte(v[31:24], gap);
         v = v << 8;
      end
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("start_loadprog", 32'(loadProgram), 32'd1);
      check("start_error", 32'(load_error), 32'd0);
      check("start_count", word_count, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_loadprog"}, 32'(loadProgram), 32'd0);
      check({tag, "_addr"}, addressInstrucctionProgram, 32'd0);
      check({tag, "_data"}, data_instruction, 32'd0);
      check({tag, "_wr"}, 32'(wr_instruction), 32'd0);
      check({tag, "_done"}, 32'(load_done), 32'd0);
      check({tag, "_error"}, 32'(load_error), 32'd0);
      check({tag, "_count"}, word_count, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles;
      rst        = 1'b0;
      load_start = 1'b0;
      rx_done    = 1'b0;
      rx_data    = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Normal program ending in the halt word.
      exp_done_count = 32'd3;
      start_load();
      send_word(32'h2001_0005, 32'd0, 1);
      send_word(32'h0000_0000, 32'd1, 1);
      send_word(32'hFFFF_FFFF, 32'd2, 1);
      repeat (4) @(negedge clk);
      check("t1_done_pulses", 32'(done_cnt), 32'd1);
      check("t1_loadprog_low", 32'(loadProgram), 32'd0);
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // Overflow: four non-halt words fill a 4-word memory.
      start_load();
      send_word(32'h0101_0101, 32'd0, 2);
      send_word(32'h0202_0202, 32'd1, 2);
      send_word(32'h0303_0303, 32'd2, 2);
      send_word(32'h0404_0404, 32'd3, 2);
      repeat (4) @(negedge clk);
      check("ovf_error", 32'(load_error), 32'd1);
      check("ovf_loadprog", 32'(loadProgram), 32'd0);
      check("ovf_count", word_count, 32'd4);
      check("ovf_no_done", 32'(done_cnt), 32'd1);
      check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

      // Timeout after two bytes of a word.
      start_load();
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      cycles = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (load_error) begin
            cycles = i;
            break;
         end
      end
      check("tmo_cycles", 32'(cycles), 32'd16);
      check("tmo_count", word_count, 32'd0);
      check("tmo_loadprog", 32'(loadProgram), 32'd0);
      @(negedge clk);

      // Back-to-back bytes, including one in the WRITE cycle.
      exp_done_count = 32'd2;
      start_load();
      send_word(32'h1234_5678, 32'd0, 0);
      send_word(32'hFFFF_FFFF, 32'd1, 0);
      repeat (4) @(negedge clk);
      check("b2b_done_pulses", 32'(done_cnt), 32'd2);
      check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

      // load_start coincident with a byte: the byte is dropped.
      load_start = 1'b1;
      rx_data    = 8'hAA;
      rx_done    = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      rx_done    = 1'b0;
      check("coin_loadprog", 32'(loadProgram), 32'd1);
      send_word(32'h1122_3344, 32'd0, 1);
      send_word(32'hFFFF_FFFF, 32'd1, 1);
      repeat (4) @(negedge clk);
      check("coin_done_pulses", 32'(done_cnt), 32'd3);
      check("coin_sb_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-word, then a fresh load from address 0.
      start_load();
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hBE, 0);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      rst = 1'b1;
      @(negedge clk);
      start_load();
      send_word(32'hCAFE_BABE, 32'd0, 1);
      send_word(32'hFFFF_FFFF, 32'd1, 1);
      repeat (4) @(negedge clk);
      check("rst_done_pulses", 32'(done_cnt), 32'd4);
      check("rst_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction-memory program-load port. Assembles a byte stream from the debug UART receiver into 32-bit instruction words and writes them sequentially into instruction memory through the fetch stage's load port (loadProgram / address / data / write strobe). Sits between the debug unit's UART RX and the instruction fetch stage. Holds the pipeline in load mode until a halt word is written, an overflow occurs, or the byte stream times out.

## Interface
- MEM_DEPTH, 256: instruction-memory depth in words; the last valid address is MEM_DEPTH-1.
- TIMEOUT_CYCLES, 1_000_000: maximum idle clock cycles between bytes of an active load.
- HALT_WORD, 32'hFFFFFFFF: end-of-program marker.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-low.
- load_start  in  1  one-cycle pulse from the debug unit to begin a load session.
- rx_data  in  8  byte from the UART receiver.
- rx_done  in  1  one-cycle strobe; rx_data is valid in this cycle.
- loadProgram  out  1  high while a session is in RECV or WRITE; drives the fetch-stage address mux.
- addressInstrucctionProgram  out  32  word address being written, zero-extended.
- data_instruction  out  32  assembled instruction word.
- wr_instruction  out  1  one-cycle write strobe to instruction memory.
- load_done  out  1  one-cycle pulse: the halt word was written.
- load_error  out  1  level: overflow or timeout; held until the next load_start or reset.
- word_count  out  32  number of words written in the current or most recent session.

## Operation
- States:
  - IDLE
  - RECV: collecting the 4 bytes of a word.
  - WRITE: one-cycle strobe.
  - DONE: one cycle.
  - ERROR
- IDLE: on load_start, clear the byte index, address, word_count, load_error and timeout counter, then go to RECV. rx_done in IDLE is ignored. If load_start and rx_done coincide, load_start wins and the byte is dropped.
- RECV:
  - Each rx_done shifts rx_data into the word, MSB first: the first byte lands in data_instruction[31:24].
  - On the 4th byte, go to WRITE.
  - load_start during RECV is ignored.
- WRITE:
  - Assert wr_instruction with the current address and data.
  - Increment word_count.
  - If the data equals HALT_WORD, go to DONE.
  - Else if the address equals MEM_DEPTH-1, go to ERROR (overflow).
  - Else increment the address and return to RECV.
  - An rx_done arriving in WRITE is accepted as byte 0 of the next word; no byte is lost.
- DONE: pulse load_done, drop loadProgram, go to IDLE.
- ERROR: load_error=1 and loadProgram=0. Stay until load_start, which restarts exactly as from IDLE.
- Timeout: the counter increments each RECV cycle without rx_done and clears on rx_done. Reaching TIMEOUT_CYCLES enters ERROR, even mid-word. The partial word is discarded and never written.
- Address arithmetic is modulo 2^32 internally, but the overflow rule above prevents it from exceeding MEM_DEPTH-1.

## Timing
- Reset values: state IDLE, all outputs 0 (data_instruction=0, addressInstrucctionProgram=0, word_count=0).
- Reset mid-session aborts immediately. No strobe is issued in the reset cycle.
- loadProgram rises the cycle after load_start is sampled. It falls on the cycle load_done pulses or ERROR is entered.
- wr_instruction is asserted exactly one cycle, one cycle after the rx_done of the 4th byte. Address and data are stable in that cycle.
- Minimum byte spacing: 1 cycle. Back-to-back rx_done is fully supported.

## Structure
- Shared package `program_loader_pkg`:
  - state enum: IDLE, RECV, WRITE, DONE, ERROR
  - HALT_WORD default
  - byte-index width
- One sub-module, `word_assembler`:
  - shift register and 2-bit byte counter
  - inputs: clr, byte strobe, byte
  - outputs: word, word_valid
- The FSM, address and word_count counters, and timeout counter live in the top level.

## Test plan
- Send load_start, then bytes 20,01,00,05, 00,00,00,00, FF,FF,FF,FF. Expect writes of 0x20010005@0, 0x00000000@1, 0xFFFFFFFF@2, then load_done with word_count=3, and loadProgram low the next cycle.
- MEM_DEPTH=4, send 4 non-halt words. Expect 4 writes at addresses 0..3, then load_error=1, load_done never asserted.
- TIMEOUT_CYCLES=16, send 2 bytes, then silence. Expect ERROR at the 16th idle cycle, no wr_instruction, word_count=0.
- Back-to-back rx_done every cycle, including the cycle of WRITE, for 8 bytes ending with a halt word. Expect 2 correct writes with no dropped byte.
- load_start coincident with rx_done (byte 0xAA), then the normal stream. Expect 0xAA absent from the first word.
- Deassert rst (drive low) after 3 bytes. Expect all outputs 0 the next cycle. Then a fresh load writes at address 0.
